// File: rtl/uart_tx_fifo_pkg.sv
// Shared types for the UART transmitter with write FIFO.
//   parity_t    : line parity mode as presented on parity_mode
//   tx_state_t  : transmitter frame FSM states
//   IDLE_LEVEL  : level of the serial line between frames
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } tx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // Reserved mode 11 behaves like no parity.
    function automatic logic parity_enabled(input parity_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port of the UART transmitter.
//   write_en/tx_in : push request and data word (host drives)
//   full/empty     : FIFO status flags
//   count          : FIFO fill level
//   overflow       : one-cycle pulse when a write was dropped
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic              write_en;
    logic [DATA_W-1:0] tx_in;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output write_en, tx_in,
        input  full, empty, count, overflow
    );

    modport slave (
        input  write_en, tx_in,
        output full, empty, count, overflow
    );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, reset      : clock, synchronous active-high reset
//   wr_en, wr_data  : push (ignored while full)
//   rd_en           : pop (ignored while empty)
//   rd_data         : head word, valid whenever empty=0
//   full, empty     : registered status flags
//   count           : registered fill level
module sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [W-1:0]                 wr_data,
    input  logic                         rd_en,
    output logic [W-1:0]                 rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full_q;
    logic             empty_q;
    logic             wr_ok;
    logic             rd_ok;
    logic [CNT_W-1:0] count_d;

    // Accept/pop qualification uses the registered flags only.
    always_comb begin
        wr_ok   = wr_en & ~full_q;
        rd_ok   = rd_en & ~empty_q;
        count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with integrated write FIFO, paced by an external baud tick.
//   clk, reset           : clock, synchronous active-high reset
//   tx_en                : baud tick, one pulse per bit period
//   parity_mode          : 00 none, 01 even, 10 odd, 11 none
//   two_stop             : 1 selects two stop bits
//   tx_out               : serial line, idles high
//   busy                 : frame in progress or data queued
//   host                 : write port (write_en, tx_in, full, empty, count, overflow)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 tx_out,
    output logic                 busy,
    uart_tx_fifo_if.slave        host
);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    tx_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shd_data_q, shd_data_d;
    parity_t           shd_par_q, shd_par_d;
    logic              shd_two_q, shd_two_d;
    logic              tx_out_q, tx_out_d;
    logic              busy_q, busy_d;
    logic              overflow_q;

    logic              pop_c;
    logic              load_c;
    logic              frame_end_c;
    logic              wr_ok_c;
    logic [DATA_W-1:0] head_data;

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (host.write_en),
        .wr_data (host.tx_in),
        .rd_en   (pop_c),
        .rd_data (head_data),
        .full    (host.full),
        .empty   (host.empty),
        .count   (host.count)
    );

    // Frame FSM: advances only on ticks; launch pops the head and snapshots config.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shd_data_d  = shd_data_q;
        shd_par_d   = shd_par_q;
        shd_two_d   = shd_two_q;
        pop_c       = 1'b0;
        load_c      = 1'b0;
        frame_end_c = 1'b0;

        if (tx_en) begin
            case (state_q)
                IDLE:   load_c = ~host.empty;
                START: begin
                    state_d = DATA;
                    idx_d   = '0;
                end
                DATA: begin
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = parity_enabled(shd_par_q) ? PARITY : STOP1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                PARITY: state_d = STOP1;
                STOP1: begin
                    if (shd_two_q) state_d = STOP2;
                    else           frame_end_c = 1'b1;
                end
                STOP2:   frame_end_c = 1'b1;
                default: state_d = IDLE;
            endcase

            // Back-to-back: the ending tick launches the next queued word.
            if (frame_end_c) begin
                if (!host.empty) load_c  = 1'b1;
                else             state_d = IDLE;
            end
        end

        if (load_c) begin
            pop_c      = 1'b1;
            state_d    = START;
            shd_data_d = head_data;
            shd_par_d  = parity_t'(parity_mode);
            shd_two_d  = two_stop;
        end
    end

    // Line level is derived from the next state so tx_out changes right after the tick.
    always_comb begin
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shd_data_d[idx_d];
            PARITY:  tx_out_d = (^shd_data_d) ^ (shd_par_d == PAR_ODD);
            default: tx_out_d = IDLE_LEVEL;
        endcase
    end

    // busy tracks the post-edge FSM state and FIFO occupancy.
    always_comb begin
        wr_ok_c = host.write_en & ~host.full;
        busy_d  = (state_d != IDLE) ||
                  ((host.count + CNT_W'(wr_ok_c) - CNT_W'(pop_c)) != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shd_data_q <= '0;
            shd_par_q  <= PAR_NONE;
            shd_two_q  <= 1'b0;
            tx_out_q   <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shd_data_q <= shd_data_d;
            shd_par_q  <= shd_par_d;
            shd_two_q  <= shd_two_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
            overflow_q <= host.write_en & host.full;
        end
    end

    assign tx_out        = tx_out_q;
    assign busy          = busy_q;
    assign host.overflow = overflow_q;

endmodule
